display_scan_ctrl: RTL
======================

# display_scan_ctrl

Time-multiplexing scheduler that shares one `sevenseg` decoder across `NUM_DIGITS` common-anode digits of the clock display. It holds a frame-coherent copy of the BCD digit vector and steps through the digits at a fixed slot rate. For each digit it inserts an anti-ghosting blank interval, drives the shared decoder's `data` input and asserts the matching active-low anode. Upstream timekeeping logic writes new digit values through a `load`/`load_ack` handshake, and those values are applied only at frame boundaries, so a displayed time never tears.

## Interface
- `NUM_DIGITS`, 4: number of multiplexed digits (2..8).
- `SCAN_DIV`, 50000: clock cycles per digit slot (≥2).
- `BLANK_CYCLES`, 500: cycles at the start of each slot with all anodes off (1..`SCAN_DIV`-1).

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `enable` in 1: scanning enabled when high.
- `digits_in` in 4·`NUM_DIGITS`: BCD digits. Digit i is at [4i+3:4i]; digit 0 is the rightmost.
- `load` in 1: request to adopt `digits_in`.
- `lz_blank` in 1: leading-zero suppression enable.
- `dec_data` out 4: feeds the shared `sevenseg` `data` input.
- `an_n` out `NUM_DIGITS`: anode enables, active-low; bit i drives digit i.
- `frame_start` out 1: one-cycle pulse at the start of the digit-0 slot.
- `load_ack` out 1: one-cycle pulse in the first cycle in which new digits are displayed.

## Operation
- **Internal state:**
  - FSM IDLE/BLANK/DRIVE.
  - Slot counter `cnt` (0..`SCAN_DIV`-1).
  - Digit index `idx` (0..`NUM_DIGITS`-1).
  - Display register `disp`.
  - Pending register `pend` and flag `pend_v`.
- **Loads:**
  - `load` high on any edge captures `digits_in` into `pend` and sets `pend_v`.
  - A later `load` before the loaded data is applied overwrites `pend`; last wins, and only one ack is issued.
- **IDLE** (`enable` low):
  - `an_n` is all ones and `cnt`, `idx` are held at 0.
  - If `pend_v` is set, it is applied on the next edge: `disp`←`pend`, `pend_v` clears, and `load_ack` pulses.
- **IDLE→BLANK:** on an edge where `enable`=1. This entry is a frame start: `cnt`=0, `idx`=0.
- **BLANK** (`cnt` < `BLANK_CYCLES`):
  - `an_n` is all ones.
  - `dec_data` = `disp[idx]`, presented early so the decoder settles before the anode turns on.
- **BLANK→DRIVE:** when `cnt` reaches `BLANK_CYCLES`.
- **DRIVE** (`cnt` ≥ `BLANK_CYCLES`):
  - `an_n` = ~(1<<`idx`), unless digit `idx` is suppressed, in which case `an_n` is all ones.
  - `dec_data` = `disp[idx]`.
- **End of slot** (`cnt`=`SCAN_DIV`-1):
  - `cnt`←0 and `idx`←`idx`+1, wrapping `NUM_DIGITS`-1→0; the FSM returns to BLANK.
  - The wrap to 0 is a frame boundary. On that edge, if `pend_v` is set (or `load` is high on the same edge), `disp` takes the newest value, `pend_v` clears, and `load_ack` pulses alongside `frame_start`.
- **Suppression:** digit i (i≥1) is dark when `lz_blank`=1 and `disp` digits i..`NUM_DIGITS`-1 are all zero. Digit 0 is never suppressed. `lz_blank` is evaluated live.
- **Invalid digits:** values >9 are passed through unmodified; the decoder renders them as its default glyph.
- **`enable` falling in BLANK or DRIVE:** the next edge enters IDLE. `an_n` is all ones from that edge, and counters reset to 0. `pend` is retained.

## Timing
- **Reset values** (edge with `reset_n`=0):
  - State IDLE; `cnt`=0; `idx`=0.
  - `disp`=0; `pend_v`=0.
  - `an_n`=all ones; `dec_data`=0; `frame_start`=0; `load_ack`=0.
- **Reset mid-operation:** all of the reset values above take effect on the very edge on which `reset_n`=0 is sampled.
- **Output registration:**
  - All outputs are decoded from registered state only; there is no combinational input→output path.
  - The exception is the `lz_blank` gating of `an_n`, which is a single AND term.
- **Frame period:** exactly `NUM_DIGITS`·`SCAN_DIV` cycles. `frame_start` is high when state≠IDLE, `idx`=0 and `cnt`=0.
- **Anode on-time:** `SCAN_DIV`-`BLANK_CYCLES` cycles per digit per frame. An anode is never low for two digits in the same cycle, or for any digit during BLANK.
- **Load latency:**
  - While scanning: at most one frame plus one cycle.
  - While in IDLE: one cycle.

## Test plan
All scenarios use `NUM_DIGITS`=4, `SCAN_DIV`=8, `BLANK_CYCLES`=2.

- **Reset:** hold `reset_n`=0 for 3 cycles with `enable`=1 and `load`=1 → `an_n`=1111, `dec_data`=0, `frame_start`=`load_ack`=0 throughout; `disp` stays 0.
- **Basic scan:** in IDLE, load `digits_in`=0x4321 (`load_ack` next cycle), then raise `enable` → per slot the sequence is:
  - cycles 0–1: `an_n`=1111 with `dec_data`=1; cycles 2–7: `an_n`=1110, `dec_data`=1;
  - cycles 10–15: `an_n`=1101, `dec_data`=2; then 1011/3, then 0111/4;
  - `frame_start` at cycles 0, 32, 64.
- **Frame-coherent load:** while scanning 0x4321, pulse `load` with 0x5678 at cycle 10, then 0x9999 at cycle 20 →
  - digits display 0x4321 through cycle 31;
  - at cycle 32 `disp`=0x9999, with a single `load_ack` coincident with `frame_start`.
- **Leading zeros:** `disp`=0x0070 with `lz_blank`=1 →
  - digits 3 and 2 keep `an_n` high for their whole slots;
  - digit 1 shows 7 (`an_n`=1101) and digit 0 shows 0 (`an_n`=1110);
  - with `disp`=0x0000, only digit 0 ever lights.
- **Enable drop / reset mid-slot:** drop `enable` at cycle 13 (digit 1, DRIVE) →
  - `an_n`=1111 from the next edge;
  - re-raising `enable` restarts at digit 0 with a `frame_start` pulse;
  - repeating the drop with `reset_n` pulsed low instead also clears `disp` to 0.

Source files
------------

// File: rtl/display_scan_ctrl_if.sv
// Upstream/decoder-facing signal bundle for the multiplexed display scanner.
// The master side is the timekeeping logic; the slave side is the scan controller.
interface display_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                      enable;
    logic [4*NUM_DIGITS-1:0]   digits_in;
    logic                      load;
    logic                      lz_blank;
    logic [3:0]                dec_data;
    logic [NUM_DIGITS-1:0]     an_n;
    logic                      frame_start;
    logic                      load_ack;

    modport master (
        output enable, digits_in, load, lz_blank,
        input  dec_data, an_n, frame_start, load_ack
    );

    modport slave (
        input  enable, digits_in, load, lz_blank,
        output dec_data, an_n, frame_start, load_ack
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan of NUM_DIGITS common-anode digits through one shared decoder,
// with anti-ghost blanking, leading-zero suppression and frame-coherent digit loads.
module display_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic               clk,
    input  logic               reset_n,
    display_scan_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam int unsigned DW = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [IW-1:0]   r_idx, w_idx_nxt;
    logic [DW-1:0]   r_disp, w_disp_nxt;
    logic [DW-1:0]   r_pend, w_pend_nxt;
    logic            r_pend_v, w_pend_v_nxt;
    logic            r_ack, w_ack_nxt;

    logic            w_end_slot;
    logic            w_last_digit;
    logic            w_blank_done;
    logic [3:0]      w_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_zero_from;
    logic            w_supp;

    assign w_end_slot   = (r_cnt == CW'(SCAN_DIV - 1));
    assign w_last_digit = (r_idx == IW'(NUM_DIGITS - 1));
    assign w_blank_done = (r_cnt == CW'(BLANK_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_disp   <= '0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_ack    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_disp   <= w_disp_nxt;
            r_pend   <= w_pend_nxt;
            r_pend_v <= w_pend_v_nxt;
            r_ack    <= w_ack_nxt;
        end
    end

    // w_pend_nxt/w_pend_v_nxt already fold in a same-edge load, so applying them gives "newest wins".
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_disp_nxt   = r_disp;
        w_pend_nxt   = r_pend;
        w_pend_v_nxt = r_pend_v;
        w_ack_nxt    = 1'b0;

        if (bus.load) begin
            w_pend_nxt   = bus.digits_in;
            w_pend_v_nxt = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (r_pend_v) begin
                    w_disp_nxt   = w_pend_nxt;
                    w_pend_v_nxt = 1'b0;
                    w_ack_nxt    = 1'b1;
                end
                if (bus.enable) begin
                    w_state_nxt = S_BLANK;
                end
            end
            S_BLANK, S_DRIVE: begin
                if (!bus.enable) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else if (w_end_slot) begin
                    w_state_nxt = S_BLANK;
                    w_cnt_nxt   = '0;
                    if (w_last_digit) begin
                        w_idx_nxt = '0;
                        if (w_pend_v_nxt) begin
                            w_disp_nxt   = w_pend_nxt;
                            w_pend_v_nxt = 1'b0;
                            w_ack_nxt    = 1'b1;
                        end
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (r_state == S_BLANK && w_blank_done) begin
                        w_state_nxt = S_DRIVE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // w_zero_from[k] is high when every displayed digit from k upward is zero.
    always_comb begin
        logic z;
        z = 1'b1;
        w_zero_from = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            w_digit[i] = r_disp[4*i +: 4];
        end
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            z = z & (r_disp[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
            w_zero_from[NUM_DIGITS-1-i] = z;
        end
    end

    assign w_supp = bus.lz_blank & (r_idx != '0) & w_zero_from[r_idx];

    assign bus.an_n        = (r_state == S_DRIVE && !w_supp) ? ~(NUM_DIGITS'(1) << r_idx) : '1;
    assign bus.dec_data    = w_digit[r_idx];
    assign bus.frame_start = (r_state != S_IDLE) && (r_idx == '0) && (r_cnt == '0);
    assign bus.load_ack    = r_ack;

endmodule
